uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte presented with a one-cycle data-ready strobe and stores it in a first-word-fall-through FIFO. It presents bytes to the consumer over a valid/ready handshake and flags overflow and inter-byte idle timeouts, so software or a packet parser can detect message boundaries.

## Interface
- DEPTH, 16, FIFO capacity in bytes; power of two, ≥ 2
- TIMEOUT_CLKS, 4340, idle clocks after the last accepted byte before o_IDLE_TIMEOUT pulses (≈ two characters at 115200 baud, 25 MHz); ≥ 1
- i_CLK  in  1  clock; all logic on rising edge
- i_RESET  in  1  synchronous, active-high reset
- i_RX_DATA  in  8  received byte; valid only when i_DATA_READY = 1
- i_DATA_READY  in  1  one-cycle strobe from the receiver: push i_RX_DATA
- o_DATA  out  8  head-of-FIFO byte; forced to 8'h00 while o_VALID = 0
- o_VALID  out  1  FIFO non-empty
- i_READY  in  1  consumer accepts o_DATA; pop = o_VALID & i_READY
- o_COUNT  out  $clog2(DEPTH)+1  bytes currently stored, 0..DEPTH
- o_FULL  out  1  o_COUNT == DEPTH
- o_EMPTY  out  1  o_COUNT == 0
- o_OVERFLOW  out  1  sticky: a byte was dropped
- i_CLR_OVF  in  1  clears o_OVERFLOW
- o_IDLE_TIMEOUT  out  1  one-cycle pulse: FIFO non-empty and no byte pushed for TIMEOUT_CLKS clocks

## Operation
- push_req = i_DATA_READY; pop = o_VALID & i_READY.
- Write accepted when push_req & (!o_FULL | pop). A push to a full FIFO with a simultaneous pop is accepted, and the count stays at DEPTH.
- Dropped write (push_req & o_FULL & !pop): memory and pointers unchanged, o_OVERFLOW ← 1.
- Overflow clear: i_CLR_OVF ← clears o_OVERFLOW. If a drop and i_CLR_OVF coincide, the set wins.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. The count register is updated +1 on push only, −1 on pop only, and is unchanged on both or neither.
- Pop from empty: impossible, because o_VALID = 0. i_READY is ignored while empty.
- Simultaneous push and pop on a one-entry FIFO: the head byte is consumed, the new byte becomes the head next cycle, and o_VALID stays 1.
- Idle timer (counter, width $clog2(TIMEOUT_CLKS+1)):
  - Cleared to 0 on every accepted write, and whenever the FIFO is empty.
  - Otherwise increments, saturating at TIMEOUT_CLKS.
  - o_IDLE_TIMEOUT = 1 for exactly the one cycle in which the counter transitions to TIMEOUT_CLKS.
  - No re-pulse until a new write restarts the timer.
  - Popping bytes does not reset the timer.
- Reset: pointers, count, timer, o_OVERFLOW and o_IDLE_TIMEOUT cleared. Memory contents are not reset.
- Reset values: o_VALID 0, o_EMPTY 1, o_FULL 0, o_COUNT 0, o_DATA 8'h00, o_OVERFLOW 0, o_IDLE_TIMEOUT 0.
- Reset mid-operation discards all stored bytes. A push strobe in the reset cycle is ignored.

## Timing
- Push at edge n (i_DATA_READY high in cycle n−1) makes the byte visible at o_DATA, with o_VALID = 1, after edge n. Write-to-output latency is 1 clock.
- Pop at edge n: the next byte (or o_VALID = 0) is presented after edge n. A sustained i_READY = 1 drains one byte per clock.
- o_FULL, o_EMPTY and o_COUNT are registered and update on the same edge as the pointers.
- o_DATA is a combinational read of the memory at rd_ptr, gated by o_VALID. No registered-output stall cycle.
- o_OVERFLOW is set on the edge after the dropped strobe.
- o_IDLE_TIMEOUT pulses TIMEOUT_CLKS edges after the last accepted write, provided the FIFO was non-empty throughout.
- The receiver strobes at most once per ~2170 clocks. The block nevertheless supports back-to-back strobes every clock.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8
  - Default CLK_FREQ = 25000000 and BAUD_RATE = 115200
  - Helper constant for the default TIMEOUT_CLKS (2 × 10 × CLK_FREQ/BAUD_RATE, rounded)
- Sub-module uart_fifo_ram:
  - Parameterised DEPTH × 8 simple dual-port memory with a synchronous write port and an asynchronous read port.
  - No reset.
- Pointer, count, overflow and timer logic live in uart_rx_fifo.

## Test plan
- Reset, then push 8'hA5 → after 1 clock: o_VALID = 1, o_DATA = 8'hA5, o_COUNT = 1. Pulse i_READY → o_EMPTY = 1, o_DATA = 8'h00.
- Push 16 bytes 8'h00..8'h0F with i_READY = 0 → o_FULL = 1, o_COUNT = 16. 17th push 8'hFF → o_OVERFLOW = 1, count stays 16. Drain yields 8'h00..8'h0F in order, with no 8'hFF.
- When full, push 8'h55 together with a pop → count stays 16, o_OVERFLOW stays 0, and 8'h55 is the last byte drained.
- Sustain i_DATA_READY and i_READY every clock for 40 bytes → every byte appears in order, count ≤ 1, both pointers wrap twice.
- Push 1 byte, then idle with TIMEOUT_CLKS = 20 → o_IDLE_TIMEOUT pulses exactly once, 20 clocks after the push. No pulse when empty. A push at clock 15 restarts the timer.
- Set o_OVERFLOW, assert i_CLR_OVF in the same cycle as a new drop → o_OVERFLOW stays 1. Assert i_CLR_OVF alone → 0. Assert i_RESET with 5 bytes stored → all outputs at their reset values the next clock.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default line timing and the derived
// two-character idle timeout used by the receive buffer.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int CLK_FREQ    = 25000000;
  localparam int BAUD_RATE   = 115200;

  // Two 10-bit characters of line time, rounded to the nearest clock.
  localparam int DEFAULT_TIMEOUT_CLKS = (2 * 10 * CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x UART_DATA_W simple dual-port storage: synchronous write, asynchronous
// read, no reset on the array.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic [UART_DATA_W-1:0] rdata_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through byte buffer with sticky overflow flag
// and a one-shot inter-byte idle timeout pulse.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1,
  localparam int TW          = $clog2(TIMEOUT_CLKS + 1)
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET,
  input  logic [UART_DATA_W-1:0] i_RX_DATA,
  input  logic                   i_DATA_READY,
  output logic [UART_DATA_W-1:0] o_DATA,
  output logic                   o_VALID,
  input  logic                   i_READY,
  output logic [CW-1:0]          o_COUNT,
  output logic                   o_FULL,
  output logic                   o_EMPTY,
  output logic                   o_OVERFLOW,
  input  logic                   i_CLR_OVF,
  output logic                   o_IDLE_TIMEOUT
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          pop_s, wr_en_s, drop_s;
  logic [UART_DATA_W-1:0] rdata_s;

  assign pop_s   = !empty_q && i_READY;
  assign wr_en_s = i_DATA_READY && (!full_q || pop_s);
  assign drop_s  = i_DATA_READY && full_q && !pop_s;

  uart_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (i_CLK),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_RX_DATA),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Next-state for pointers, occupancy, overflow flag and idle timer.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (wr_en_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !wr_en_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    // A drop coinciding with a clear leaves the flag set.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (i_CLR_OVF) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (wr_en_s || empty_q) begin
      timer_d = '0;
    end else if (timer_q != TW'(TIMEOUT_CLKS)) begin
      timer_d   = timer_q + TW'(1);
      timeout_d = (timer_q == TW'(TIMEOUT_CLKS - 1));
    end else begin
      timer_d = timer_q;
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // State registers with synchronous reset; memory is deliberately untouched.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_VALID        = !empty_q;
  assign o_DATA         = empty_q ? 8'h00 : rdata_s;
  assign o_COUNT        = count_q;
  assign o_FULL         = full_q;
  assign o_EMPTY        = empty_q;
  assign o_OVERFLOW     = ovf_q;
  assign o_IDLE_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for the basic handshake
// plus hand sequences for fill/overflow, wrap streaming, timeout and reset.
module tb_uart_rx_fifo;

  logic       i_CLK = 1'b0;
  logic       i_RESET = 1'b0;
  logic [7:0] i_RX_DATA = 8'h00;
  logic       i_DATA_READY = 1'b0;
  logic [7:0] o_DATA;
  logic       o_VALID;
  logic       i_READY = 1'b0;
  logic [4:0] o_COUNT;
  logic       o_FULL, o_EMPTY, o_OVERFLOW;
  logic       i_CLR_OVF = 1'b0;
  logic       o_IDLE_TIMEOUT;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .TIMEOUT_CLKS(20)) dut (
    .i_CLK          (i_CLK),
    .i_RESET        (i_RESET),
    .i_RX_DATA      (i_RX_DATA),
    .i_DATA_READY   (i_DATA_READY),
    .o_DATA         (o_DATA),
    .o_VALID        (o_VALID),
    .i_READY        (i_READY),
    .o_COUNT        (o_COUNT),
    .o_FULL         (o_FULL),
    .o_EMPTY        (o_EMPTY),
    .o_OVERFLOW     (o_OVERFLOW),
    .i_CLR_OVF      (i_CLR_OVF),
    .o_IDLE_TIMEOUT (o_IDLE_TIMEOUT)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic       rst;
    logic       dr;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       to;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, and settle 1 time unit past it.
  task automatic step(input logic dr, input logic [7:0] d, input logic rdy,
                      input logic clr, input logic rst);
    i_DATA_READY = dr;
    i_RX_DATA    = d;
    i_READY      = rdy;
    i_CLR_OVF    = clr;
    i_RESET      = rst;
    @(posedge i_CLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(o_VALID), 32'd0);
    chk({tag, "_empty"}, 32'(o_EMPTY), 32'd1);
    chk({tag, "_full"},  32'(o_FULL),  32'd0);
    chk({tag, "_count"}, 32'(o_COUNT), 32'd0);
    chk({tag, "_data"},  32'(o_DATA),  32'h00);
    chk({tag, "_ovf"},   32'(o_OVERFLOW), 32'd0);
    chk({tag, "_to"},    32'(o_IDLE_TIMEOUT), 32'd0);
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int i = 0; i < 16; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs [11];

  initial begin
    int pulses;
    int pulse_at;
    logic [7:0] b;

    // rst dr din rdy clr | valid dout cnt full empty ovf to
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int v = 0; v < 11; v++) begin
      step(vecs[v].dr, vecs[v].din, vecs[v].rdy, vecs[v].clr, vecs[v].rst);
      chk($sformatf("vec%0d_valid", v), 32'(o_VALID), 32'(vecs[v].valid));
      chk($sformatf("vec%0d_data", v),  32'(o_DATA),  32'(vecs[v].dout));
      chk($sformatf("vec%0d_count", v), 32'(o_COUNT), 32'(vecs[v].cnt));
      chk($sformatf("vec%0d_full", v),  32'(o_FULL),  32'(vecs[v].full));
      chk($sformatf("vec%0d_empty", v), 32'(o_EMPTY), 32'(vecs[v].empty));
      chk($sformatf("vec%0d_ovf", v),   32'(o_OVERFLOW), 32'(vecs[v].ovf));
      chk($sformatf("vec%0d_to", v),    32'(o_IDLE_TIMEOUT), 32'(vecs[v].to));
    end

    // Fill, overflow on the 17th byte, then drain in order.
    fill16(8'h00);
    chk("fill_full", 32'(o_FULL), 32'd1);
    chk("fill_count", 32'(o_COUNT), 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf", 32'(o_OVERFLOW), 32'd1);
    chk("drop_count", 32'(o_COUNT), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(o_DATA), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(o_EMPTY), 32'd1);
    chk("drain_data0", 32'(o_DATA), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(o_OVERFLOW), 32'd0);

    // Push into a full FIFO with a simultaneous pop.
    fill16(8'h80);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 32'(o_COUNT), 32'd16);
    chk("fullpp_ovf", 32'(o_OVERFLOW), 32'd0);
    chk("fullpp_full", 32'(o_FULL), 32'd1);
    for (int i = 1; i < 17; i++) begin
      b = (i == 16) ? 8'h55 : 8'h80 + 8'(i);
      chk($sformatf("fullpp_drain_%0d", i), 32'(o_DATA), 32'(b));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("fullpp_empty", 32'(o_EMPTY), 32'd1);

    // Back-to-back push and pop for 40 bytes; pointers wrap twice.
    for (int k = 0; k < 40; k++) begin
      b = 8'(k * 7 + 3);
      step(1'b1, b, 1'b1, 1'b0, 1'b0);
      chk($sformatf("stream_data_%0d", k), 32'(o_DATA), 32'(b));
      chk($sformatf("stream_cnt_%0d", k), 32'(o_COUNT <= 5'd1), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("stream_empty", 32'(o_EMPTY), 32'd1);

    // Single byte then idle: one pulse exactly 20 edges after the push.
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    pulse_at = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (o_IDLE_TIMEOUT) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_pulse_at", 32'(pulse_at), 32'd20);

    // Empty FIFO: no pulse.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (o_IDLE_TIMEOUT) pulses++;
    end
    chk("to_empty_none", 32'(pulses), 32'd0);

    // Second push at step 15 restarts the timer: pulse at step 35 only.
    pulses = 0;
    pulse_at = -1;
    for (int j = 0; j < 45; j++) begin
      step((j == 0) || (j == 15), 8'(j), 1'b0, 1'b0, 1'b0);
      if (o_IDLE_TIMEOUT) begin
        pulses++;
        if (pulse_at < 0) pulse_at = j;
      end
    end
    chk("to_restart_pulses", 32'(pulses), 32'd1);
    chk("to_restart_at", 32'(pulse_at), 32'd35);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Drop coinciding with clear keeps the flag; clear alone drops it.
    fill16(8'h40);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(o_OVERFLOW), 32'd1);
    step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(o_OVERFLOW), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clear", 32'(o_OVERFLOW), 32'd0);
    chk("ovf_clear_count", 32'(o_COUNT), 32'd16);

    // Reset with five bytes stored.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(o_COUNT), 32'd5);
    chk("pre_rst_data", 32'(o_DATA), 32'h10);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_reset_state("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
